// File: rtl/dp_bram_pkg.sv
// Shared constants and helpers for the dual-port block RAM.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package dp_bram_pkg;

  // Cross-port same-address collision behaviour seen by port B
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Number of byte lanes in a word
  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dp_bram_if.sv
// Request/response bundle for both RAM ports (A read/write, B read-only).
// Latency: n/a (wiring only).
// Backpressure: valid/ready on request and response channels of each port.
interface dp_bram_if
  import dp_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = lane_count(DATA_WIDTH);

  logic                  a_req_valid;
  logic                  a_req_ready;
  logic                  a_we;
  logic [BE_W-1:0]       a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rsp_valid;
  logic                  a_rsp_ready;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req_valid;
  logic                  b_req_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_rsp_valid;
  logic                  b_rsp_ready;
  logic [DATA_WIDTH-1:0] b_rdata;

  modport master (
    output a_req_valid, a_we, a_be, a_addr, a_wdata, a_rsp_ready,
    output b_req_valid, b_addr, b_rsp_ready,
    input  a_req_ready, a_rsp_valid, a_rdata,
    input  b_req_ready, b_rsp_valid, b_rdata
  );

  modport slave (
    input  a_req_valid, a_we, a_be, a_addr, a_wdata, a_rsp_ready,
    input  b_req_valid, b_addr, b_rsp_ready,
    output a_req_ready, a_rsp_valid, a_rdata,
    output b_req_ready, b_rsp_valid, b_rdata
  );

endinterface

// File: rtl/dp_bram_rsp_fifo.sv
// Two-entry response FIFO with fall-through when empty.
// Latency: 0 cycles when empty (input visible at output same cycle), else queued.
// Backpressure: holds data while out_rdy=0; caller guarantees at most 2 entries via credits.
module rsp_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   count
);
  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         empty;
  logic         bypass;
  logic         store;
  logic         drain;

  assign empty   = (cnt == 2'd0);
  // An arriving word that is consumed immediately never occupies a slot
  assign bypass  = empty & in_vld & out_rdy;
  assign store   = in_vld & ~bypass;
  assign drain   = out_vld & out_rdy & ~empty;
  assign out_vld = ~empty | in_vld;
  assign out_dat = !empty ? slot[rd_ptr] : (in_vld ? in_dat : '0);
  assign count   = cnt;

  // Slot storage and pointers; store+drain at full rewrites the slot being popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      if (store) begin
        slot[wr_ptr] <= in_dat;
        wr_ptr       <= ~wr_ptr;
      end
      if (drain) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, store} - {1'b0, drain};
    end
  end

endmodule

// File: rtl/dp_bram.sv
// True dual-port byte-write RAM: port A read/write, port B read-only, per-port response FIFOs.
// Latency: read data valid 1+OUT_REG cycles after request acceptance.
// Backpressure: req_ready drops once 2 reads are outstanding (in flight + queued) with no pop.
module dp_bram
  import dp_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = RDW_READ_FIRST
) (
  input logic      clk,
  input logic      rst,
  dp_bram_if.slave bus
);
  localparam int BE_W  = lane_count(DATA_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  a_acc;
  logic                  a_wr;
  logic                  a_rd;
  logic                  b_rd;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] b_word;
  logic [DATA_WIDTH-1:0] byp_dat;
  logic [BE_W-1:0]       byp_be;
  logic                  byp_vld;
  logic                  a_s1;
  logic                  b_s1;
  logic                  a_fv;
  logic                  b_fv;
  logic [DATA_WIDTH-1:0] a_fd;
  logic [DATA_WIDTH-1:0] b_fd;
  logic [1:0]            a_infl;
  logic [1:0]            b_infl;
  logic [1:0]            a_cnt;
  logic [1:0]            b_cnt;
  logic [2:0]            a_outst;
  logic [2:0]            b_outst;
  logic                  a_pop;
  logic                  b_pop;

  assign a_acc = bus.a_req_valid & bus.a_req_ready;
  assign a_wr  = a_acc & bus.a_we;
  assign a_rd  = a_acc & ~bus.a_we;
  assign b_rd  = bus.b_req_valid & bus.b_req_ready;

  // One RAM per byte lane keeps byte enables a plain per-lane write enable
  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] a_byte;
    logic [7:0] b_byte;

    // Port A lane: masked write, synchronous read (never both in one cycle)
    always_ff @(posedge clk) begin
      if (a_wr && bus.a_be[g]) begin
        ram[bus.a_addr] <= bus.a_wdata[8*g +: 8];
      end
      if (a_rd) begin
        a_byte <= ram[bus.a_addr];
      end
    end

    // Port B lane: synchronous read, returns the pre-write contents on collision
    always_ff @(posedge clk) begin
      if (b_rd) begin
        b_byte <= ram[bus.b_addr];
      end
    end

    assign a_q[8*g +: 8] = a_byte;
    assign b_q[8*g +: 8] = b_byte;
  end

  // Flag a same-address A write alongside a B read when B must see the new bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_vld <= 1'b0;
    end else begin
      byp_vld <= (RDW_MODE == RDW_WRITE_FIRST) && b_rd && a_wr &&
                 (bus.a_addr == bus.b_addr);
    end
  end

  // Bypass payload, only consulted while byp_vld is set
  always_ff @(posedge clk) begin
    byp_dat <= bus.a_wdata;
    byp_be  <= bus.a_be;
  end

  // Overlay enabled bytes of the colliding write onto the RAM output
  always_comb begin
    b_word = b_q;
    if (byp_vld) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byp_be[i]) begin
          b_word[8*i +: 8] = byp_dat[8*i +: 8];
        end
      end
    end
  end

  // Read-issued flags; reset discards any read still in the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1 <= 1'b0;
      b_s1 <= 1'b0;
    end else begin
      a_s1 <= a_rd;
      b_s1 <= b_rd;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  a_s2;
    logic                  b_s2;
    logic [DATA_WIDTH-1:0] a_d2;
    logic [DATA_WIDTH-1:0] b_d2;

    // Extra output register stage ahead of the response FIFOs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_s2 <= 1'b0;
        b_s2 <= 1'b0;
        a_d2 <= '0;
        b_d2 <= '0;
      end else begin
        a_s2 <= a_s1;
        b_s2 <= b_s1;
        if (a_s1) a_d2 <= a_q;
        if (b_s1) b_d2 <= b_word;
      end
    end

    assign a_fv   = a_s2;
    assign a_fd   = a_d2;
    assign b_fv   = b_s2;
    assign b_fd   = b_d2;
    assign a_infl = {1'b0, a_s1} + {1'b0, a_s2};
    assign b_infl = {1'b0, b_s1} + {1'b0, b_s2};
  end else begin : g_noreg
    assign a_fv   = a_s1;
    assign a_fd   = a_q;
    assign b_fv   = b_s1;
    assign b_fd   = b_word;
    assign a_infl = {1'b0, a_s1};
    assign b_infl = {1'b0, b_s1};
  end

  // Credit check: in-flight reads plus queued responses may never exceed 2
  assign a_outst = {1'b0, a_infl} + {1'b0, a_cnt};
  assign b_outst = {1'b0, b_infl} + {1'b0, b_cnt};
  assign a_pop   = bus.a_rsp_valid & bus.a_rsp_ready;
  assign b_pop   = bus.b_rsp_valid & bus.b_rsp_ready;

  assign bus.a_req_ready = ~rst & ((a_outst < 3'd2) | a_pop);
  assign bus.b_req_ready = ~rst & ((b_outst < 3'd2) | b_pop);

  rsp_fifo #(.W(DATA_WIDTH)) u_a_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (a_fv),
    .in_dat  (a_fd),
    .out_vld (bus.a_rsp_valid),
    .out_rdy (bus.a_rsp_ready),
    .out_dat (bus.a_rdata),
    .count   (a_cnt)
  );

  rsp_fifo #(.W(DATA_WIDTH)) u_b_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (b_fv),
    .in_dat  (b_fd),
    .out_vld (bus.b_rsp_valid),
    .out_rdy (bus.b_rsp_ready),
    .out_dat (bus.b_rdata),
    .count   (b_cnt)
  );

endmodule

// File: tb/tb_dp_bram.sv
// Directed bench for dp_bram: dut0 is OUT_REG=0/read-first, dut1 is OUT_REG=1/write-first.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low on port B.
module tb_dp_bram;
  import dp_bram_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic          arv   [2];
  logic          awe   [2];
  logic [BW-1:0] abe   [2];
  logic [AW-1:0] aaddr [2];
  logic [DW-1:0] awd   [2];
  logic          arr   [2];
  logic          brv   [2];
  logic [AW-1:0] baddr [2];
  logic          brr   [2];
  logic          arrdy [2];
  logic          arsv  [2];
  logic [DW-1:0] ard   [2];
  logic          brrdy [2];
  logic          brsv  [2];
  logic [DW-1:0] brd   [2];

  dp_bram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  dp_bram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.a_req_valid = arv[0];
  assign bus0.a_we        = awe[0];
  assign bus0.a_be        = abe[0];
  assign bus0.a_addr      = aaddr[0];
  assign bus0.a_wdata     = awd[0];
  assign bus0.a_rsp_ready = arr[0];
  assign bus0.b_req_valid = brv[0];
  assign bus0.b_addr      = baddr[0];
  assign bus0.b_rsp_ready = brr[0];
  assign arrdy[0] = bus0.a_req_ready;
  assign arsv[0]  = bus0.a_rsp_valid;
  assign ard[0]   = bus0.a_rdata;
  assign brrdy[0] = bus0.b_req_ready;
  assign brsv[0]  = bus0.b_rsp_valid;
  assign brd[0]   = bus0.b_rdata;

  assign bus1.a_req_valid = arv[1];
  assign bus1.a_we        = awe[1];
  assign bus1.a_be        = abe[1];
  assign bus1.a_addr      = aaddr[1];
  assign bus1.a_wdata     = awd[1];
  assign bus1.a_rsp_ready = arr[1];
  assign bus1.b_req_valid = brv[1];
  assign bus1.b_addr      = baddr[1];
  assign bus1.b_rsp_ready = brr[1];
  assign arrdy[1] = bus1.a_req_ready;
  assign arsv[1]  = bus1.a_rsp_valid;
  assign ard[1]   = bus1.a_rdata;
  assign brrdy[1] = bus1.b_req_ready;
  assign brsv[1]  = bus1.b_rsp_valid;
  assign brd[1]   = bus1.b_rdata;

  dp_bram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .RDW_MODE(RDW_READ_FIRST))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  dp_bram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .RDW_MODE(RDW_WRITE_FIRST))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for port A request ready on DUT d
  task automatic wait_a(input int d);
    #1;
    for (int n = 0; n < 8 && !arrdy[d]; n++) tick();
    chk("a_req_ready", arrdy[d], 1'b1);
  endtask

  task automatic wait_b(input int d);
    #1;
    for (int n = 0; n < 8 && !brrdy[d]; n++) tick();
    chk("b_req_ready", brrdy[d], 1'b1);
  endtask

  task automatic a_write(input int d, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                         input logic [BW-1:0] be);
    arv[d] = 1'b1; awe[d] = 1'b1; aaddr[d] = ad; awd[d] = wd; abe[d] = be;
    wait_a(d);
    tick();
    arv[d] = 1'b0; awe[d] = 1'b0;
  endtask

  task automatic a_read(input int d, input logic [AW-1:0] ad, input logic [DW-1:0] exp,
                        input int lat, input string tag);
    arv[d] = 1'b1; awe[d] = 1'b0; aaddr[d] = ad; abe[d] = '1;
    wait_a(d);
    tick();
    arv[d] = 1'b0;
    for (int n = 1; n < lat; n++) begin
      chk({tag, "_early"}, arsv[d], 1'b0);
      tick();
    end
    chk({tag, "_vld"}, arsv[d], 1'b1);
    chk({tag, "_dat"}, ard[d], exp);
    tick();
  endtask

  task automatic b_read(input int d, input logic [AW-1:0] ad, input logic [DW-1:0] exp,
                        input int lat, input string tag);
    brv[d] = 1'b1; baddr[d] = ad;
    wait_b(d);
    tick();
    brv[d] = 1'b0;
    for (int n = 1; n < lat; n++) begin
      chk({tag, "_early"}, brsv[d], 1'b0);
      tick();
    end
    chk({tag, "_vld"}, brsv[d], 1'b1);
    chk({tag, "_dat"}, brd[d], exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      arv[d] = 1'b0; awe[d] = 1'b0; abe[d] = '0; aaddr[d] = '0; awd[d] = '0; arr[d] = 1'b1;
      brv[d] = 1'b0; baddr[d] = '0; brr[d] = 1'b1;
    end

    // Reset state
    #2;
    chk("rst_a_req_ready", arrdy[0], 1'b0);
    chk("rst_b_req_ready", brrdy[0], 1'b0);
    chk("rst_a_rsp_valid", arsv[0], 1'b0);
    chk("rst_b_rsp_valid", brsv[1], 1'b0);
    chk("rst_a_rdata", ard[0], 32'h0);
    chk("rst_b_rdata", brd[1], 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rel_a_req_ready0", arrdy[0], 1'b1);
    chk("rel_b_req_ready0", brrdy[0], 1'b1);
    chk("rel_a_req_ready1", arrdy[1], 1'b1);
    tick();

    // Full write then read-after-write, single-cycle latency
    a_write(0, 10'd5, 32'hDEADBEEF, 4'hF);
    a_read(0, 10'd5, 32'hDEADBEEF, 1, "raw_full");

    // Partial byte writes
    a_write(0, 10'd5, 32'h0000AA00, 4'h2);
    a_read(0, 10'd5, 32'hDEADAAEF, 1, "be_lane1");
    a_write(0, 10'd5, 32'h12345678, 4'h9);
    a_read(0, 10'd5, 32'h12ADAA78, 1, "be_lane03");

    // Same-cycle collision, read-first DUT
    a_write(0, 10'd7, 32'h0, 4'hF);
    arv[0] = 1'b1; awe[0] = 1'b1; aaddr[0] = 10'd7; awd[0] = 32'h11111111; abe[0] = 4'hF;
    brv[0] = 1'b1; baddr[0] = 10'd7;
    #1;
    chk("coll0_a_rdy", arrdy[0], 1'b1);
    chk("coll0_b_rdy", brrdy[0], 1'b1);
    tick();
    arv[0] = 1'b0; awe[0] = 1'b0; brv[0] = 1'b0;
    chk("coll0_vld", brsv[0], 1'b1);
    chk("coll0_old", brd[0], 32'h0);
    tick();
    a_read(0, 10'd7, 32'h11111111, 1, "coll0_after");

    // Same-cycle collision, write-first DUT with partial enables and 2-cycle latency
    a_write(1, 10'd7, 32'h0, 4'hF);
    arv[1] = 1'b1; awe[1] = 1'b1; aaddr[1] = 10'd7; awd[1] = 32'h11111111; abe[1] = 4'h5;
    brv[1] = 1'b1; baddr[1] = 10'd7;
    #1;
    chk("coll1_b_rdy", brrdy[1], 1'b1);
    tick();
    arv[1] = 1'b0; awe[1] = 1'b0; brv[1] = 1'b0;
    chk("coll1_early", brsv[1], 1'b0);
    tick();
    chk("coll1_vld", brsv[1], 1'b1);
    chk("coll1_merged", brd[1], 32'h00110011);
    tick();
    a_read(1, 10'd7, 32'h00110011, 2, "coll1_after");

    // Port B backpressure: two credits, then ordered drain
    a_write(0, 10'd1, 32'hA1, 4'hF);
    a_write(0, 10'd2, 32'hA2, 4'hF);
    a_write(0, 10'd3, 32'hA3, 4'hF);
    brr[0] = 1'b0;
    brv[0] = 1'b1; baddr[0] = 10'd1;
    #1;
    chk("bp_rdy_1", brrdy[0], 1'b1);
    tick();
    baddr[0] = 10'd2;
    #1;
    chk("bp_rdy_2", brrdy[0], 1'b1);
    tick();
    baddr[0] = 10'd3;
    #1;
    chk("bp_rdy_full", brrdy[0], 1'b0);
    tick();
    chk("bp_rdy_hold", brrdy[0], 1'b0);
    chk("bp_head_vld", brsv[0], 1'b1);
    chk("bp_head_dat", brd[0], 32'hA1);
    brr[0] = 1'b1;
    #1;
    chk("bp_rdy_pop", brrdy[0], 1'b1);
    tick();
    brv[0] = 1'b0;
    chk("bp_second", brd[0], 32'hA2);
    tick();
    chk("bp_third_vld", brsv[0], 1'b1);
    chk("bp_third", brd[0], 32'hA3);
    tick();
    chk("bp_empty", brsv[0], 1'b0);

    // Back-to-back reads through the output register stage
    for (int i = 0; i < 16; i++) a_write(1, AW'(i), 32'h5A000000 | i, 4'hF);
    for (int k = 0; k < 19; k++) begin
      arv[1] = (k < 16); awe[1] = 1'b0; aaddr[1] = AW'(k);
      #1;
      if (k < 16) chk("b2b_rdy", arrdy[1], 1'b1);
      chk("b2b_vld", arsv[1], (k >= 2 && k < 18));
      if (k >= 2 && k < 18) chk("b2b_dat", ard[1], 32'h5A000000 | (k - 2));
      tick();
    end
    arv[1] = 1'b0;

    // Reset with two B reads outstanding; memory survives
    brr[0] = 1'b0;
    brv[0] = 1'b1; baddr[0] = 10'd5;
    tick();
    baddr[0] = 10'd1;
    tick();
    brv[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_b_vld", brsv[0], 1'b0);
    chk("mid_rst_b_dat", brd[0], 32'h0);
    chk("mid_rst_b_rdy", brrdy[0], 1'b0);
    chk("mid_rst_a_rdy", arrdy[0], 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_b_rdy", brrdy[0], 1'b1);
    chk("post_rst_b_vld", brsv[0], 1'b0);
    brr[0] = 1'b1;
    tick();
    b_read(0, 10'd5, 32'h12ADAA78, 1, "post_rst_b5");
    a_read(0, 10'd7, 32'h11111111, 1, "post_rst_a7");
    b_read(1, 10'd7, 32'h5A000007, 2, "post_rst_d1_b7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_bram.md
DP_BRAM -- requirements
Module: dp_bram

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word address width (depth 2**ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 32, word width; SHALL be a multiple of 8.
REQ-003 Parameter OUT_REG, default 0, 1 adds an output register stage (read latency 2 instead of 1).
REQ-004 Parameter RDW_MODE, default 0, cross-port same-address collision: 0 read-first (old data), 1 write-first (new data).
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 a_req_valid  in  1  port A request valid.
REQ-008 a_req_ready  out  1  port A request accepted when valid&ready.
REQ-009 a_we  in  1  port A 1=write, 0=read.
REQ-010 a_be  in  DATA_WIDTH/8  port A byte enables, write only.
REQ-011 a_addr  in  ADDR_WIDTH  port A word address.
REQ-012 a_wdata  in  DATA_WIDTH  port A write data.
REQ-013 a_rsp_valid  out  1  port A read data valid.
REQ-014 a_rsp_ready  in  1  port A response consumer ready.
REQ-015 a_rdata  out  DATA_WIDTH  port A read data.
REQ-016 b_req_valid / b_req_ready / b_addr  in/out/in  1/1/ADDR_WIDTH  port B read-only request.
REQ-017 b_rsp_valid / b_rsp_ready / b_rdata  out/in/out  1/1/DATA_WIDTH  port B response.

Function
REQ-018 Request transfers on a rising edge with req_valid&req_ready; response transfers with rsp_valid&rsp_ready.
REQ-019 Accepted write SHALL update only bytes with a_be[i]=1 at that edge; writes produce no response.
REQ-020 Accepted read SHALL present data (rsp_valid=1) exactly 1+OUT_REG cycles after acceptance when the response path is empty and rsp_ready=1.
REQ-021 Each port SHALL hold a 2-entry response FIFO; rsp_valid = FIFO not empty, rdata = FIFO head.
REQ-022 Per port, outstanding = reads in flight + FIFO occupancy; req_ready SHALL be 0 when outstanding equals 2 and no response pops this cycle, else 1.
REQ-023 Port A write requests SHALL be accepted whenever a_req_ready=1 and consume no FIFO credit.
REQ-024 Responses SHALL return in request order per port; no response dropped or duplicated under any rsp_ready pattern.
REQ-025 Port A read after own write to same address in the previous accepted cycle SHALL return the new data.
REQ-026 Same-cycle A write and B read at the same address SHALL return old word (RDW_MODE=0) or merged new word (RDW_MODE=1, only enabled bytes new).
REQ-027 Same-cycle A read and A write impossible (single request); a_be ignored on reads.
REQ-028 Simultaneous FIFO push and pop at full SHALL be allowed; occupancy unchanged.
REQ-029 Address wraps naturally; no out-of-range condition exists.

Reset
REQ-030 rst=1 SHALL immediately clear rsp_valid (both ports), FIFOs, in-flight flags and a_rdata/b_rdata to 0.
REQ-031 req_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-032 Memory contents SHALL NOT be reset; in-flight reads during reset are discarded.

Structure
REQ-033 Shared package holds RDW_READ_FIRST/RDW_WRITE_FIRST constants and a function computing byte-lane count.
REQ-034 The 2-entry response FIFO SHALL be a sub-module named rsp_fifo, instantiated once per port.
REQ-035 Memory array SHALL remain inferable as true dual-port block RAM (no reset, no async read).

Verification
REQ-036 Write addr 5 = 0xDEADBEEF be=0xF, then A read 5, OUT_REG=0 -> a_rsp_valid one cycle after acceptance, a_rdata=0xDEADBEEF.
REQ-037 Over 0xDEADBEEF write addr 5 be=0x2 data 0x0000AA00 -> read 5 returns 0xDEADAAEF.
REQ-038 A writes addr 7=0x11111111 (old 0x0) while B reads 7 same cycle -> b_rdata 0x0 (RDW_MODE=0), 0x11111111 (RDW_MODE=1).
REQ-039 b_rsp_ready=0, B issues reads 1,2,3 -> two accepted, b_req_ready=0; release ready -> data 1,2,then 3 in order.
REQ-040 OUT_REG=1, back-to-back A reads 0..15 with rsp_ready=1 -> 2-cycle latency, one response per cycle after fill.
REQ-041 Assert rst with two B reads outstanding -> b_rsp_valid=0 immediately; after release, prior memory data still readable.
